// File: rtl/reg_scan_check_pkg.sv
// Shared encodings for the register-bank integrity scanner.
package reg_scan_check_pkg;

  localparam logic [1:0] MODE_SUM = 2'd0;
  localparam logic [1:0] MODE_XOR = 2'd1;
  localparam logic [1:0] MODE_CRC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Minimum of one bit so a two-register bank still gets an index port.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/reg_scan_check_if.sv
// Control/status bundle between the scanner and whatever drives/observes it.
interface reg_scan_check_if
  import reg_scan_check_pkg::*;
#(
  parameter int NUM_REGS = 128,
  parameter int REG_W    = 8,
  parameter int ACC_W    = 8
) ();

  localparam int IDX_W = clog2(NUM_REGS);

  logic                      CK_EE_i;
  logic                      START_i;
  logic                      CONT_i;
  logic [1:0]                MODE_i;
  logic [NUM_REGS*REG_W-1:0] DATss_i;
  logic                      BUSY_o;
  logic                      DONE_o;
  logic [ACC_W-1:0]          RES_o;
  logic                      PAR_o;
  logic                      CHG_o;
  logic [IDX_W-1:0]          IDX_o;

  modport master (
    output CK_EE_i, START_i, CONT_i, MODE_i, DATss_i,
    input  BUSY_o, DONE_o, RES_o, PAR_o, CHG_o, IDX_o
  );

  modport slave (
    input  CK_EE_i, START_i, CONT_i, MODE_i, DATss_i,
    output BUSY_o, DONE_o, RES_o, PAR_o, CHG_o, IDX_o
  );

endinterface

// File: rtl/reg_scan_check_crc_step.sv
// One register's worth of serial CRC steps, unrolled combinationally (MSB first).
module reg_scan_crc_step #(
  parameter int               ACC_W    = 8,
  parameter int               REG_W    = 8,
  parameter logic [ACC_W-1:0] CRC_POLY = 8'h07
) (
  input  logic [ACC_W-1:0] crc_in,
  input  logic [REG_W-1:0] data,
  output logic [ACC_W-1:0] crc_out
);

  logic fb;

  always_comb begin
    crc_out = crc_in;
    fb      = 1'b0;
    for (int i = REG_W - 1; i >= 0; i--) begin
      fb      = crc_out[ACC_W-1] ^ data[i];
      crc_out = (crc_out << 1) ^ (fb ? CRC_POLY : '0);
    end
  end

endmodule

// File: rtl/reg_scan_check.sv
// Walks the register image one entry per enabled clock and folds it into a
// SUM / XOR / CRC signature; holds the result and flags changes between scans.
module reg_scan_check
  import reg_scan_check_pkg::*;
#(
  parameter int               NUM_REGS = 128,
  parameter int               REG_W    = 8,
  parameter int               ACC_W    = 8,
  parameter logic [ACC_W-1:0] CRC_POLY = 8'h07,
  parameter logic [ACC_W-1:0] CRC_INIT = 8'h00
) (
  input logic              CK_i,
  input logic              ARST_i,
  reg_scan_check_if.slave  bus
);

  localparam int               IDX_W    = clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ACC_W-1:0] res_q, res_d;
  logic             chg_q, chg_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic [REG_W-1:0] cur_reg;
  logic [ACC_W-1:0] crc_next;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] acc_init;

  // Image is read live at the current index, never snapshotted.
  assign cur_reg  = bus.DATss_i[int'(idx_q)*REG_W +: REG_W];
  assign acc_init = (bus.MODE_i == MODE_CRC) ? CRC_INIT : '0;

  reg_scan_crc_step #(
    .ACC_W   (ACC_W),
    .REG_W   (REG_W),
    .CRC_POLY(CRC_POLY)
  ) u_crc_step (
    .crc_in (acc_q),
    .data   (cur_reg),
    .crc_out(crc_next)
  );

  always_comb begin
    case (mode_q)
      MODE_XOR: acc_next = acc_q ^ ACC_W'(cur_reg);
      MODE_CRC: acc_next = crc_next;
      default:  acc_next = acc_q + ACC_W'(cur_reg);
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    res_d   = res_q;
    chg_d   = chg_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    if (bus.CK_EE_i) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.START_i) begin
            mode_d  = bus.MODE_i;
            acc_d   = acc_init;
            idx_d   = '0;
            state_d = ST_SCAN;
          end
        end
        ST_SCAN: begin
          acc_d = acc_next;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_FIN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        ST_FIN: begin
          res_d   = acc_q;
          done_d  = 1'b1;
          chg_d   = valid_q & (acc_q != res_q);
          valid_d = 1'b1;
          if (bus.CONT_i) begin
            mode_d  = bus.MODE_i;
            acc_d   = acc_init;
            state_d = ST_SCAN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_SUM;
      acc_q   <= '0;
      idx_q   <= '0;
      res_q   <= '0;
      chg_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      chg_q   <= chg_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.BUSY_o = (state_q != ST_IDLE);
  assign bus.DONE_o = done_q;
  assign bus.RES_o  = res_q;
  assign bus.PAR_o  = ^res_q;
  assign bus.CHG_o  = chg_q;
  assign bus.IDX_o  = idx_q;

endmodule

// File: doc/reg_scan_check.md
Name: reg_scan_check

Overview:
- Parametrised register-bank integrity scanner; generalises the top-level byte-walk checksum over the JTAG register image.
- Walks a flat vector of NUM_REGS registers, REG_W bits each, one register per enabled clock.
- Accumulates a result in a run-time selected mode: additive sum, XOR fold or CRC.
- Holds the result, pulses DONE, flags changes versus the previous scan, and can rescan continuously.
- Sits beside the JTAG register bank in board tops; result feeds a debug pin, LED or read-back register.

Parameters:
- NUM_REGS, 128, registers in DATss_i (>=2).
- REG_W, 8, bits per register (1..32).
- ACC_W, 8, accumulator/result width (>=REG_W for SUM/XOR; CRC width).
- CRC_POLY, 8'h07, CRC polynomial, ACC_W bits, implicit top bit, MSB-first, non-reflected.
- CRC_INIT, 8'h00, CRC start value.

Ports:
- CK_i  in  1  clock
- ARST_i  in  1  asynchronous reset, active-high
- CK_EE_i  in  1  clock enable; all state advances only when high
- START_i  in  1  start request, level-sampled when idle
- CONT_i  in  1  continuous mode: restart immediately after each finish
- MODE_i  in  2  0=SUM, 1=XOR, 2=CRC, 3=SUM (reserved)
- DATss_i  in  NUM_REGS*REG_W  register image; reg k = DATss_i[k*REG_W +: REG_W]
- BUSY_o  out  1  scan in progress
- DONE_o  out  1  one-cycle pulse, result updated
- RES_o  out  ACC_W  last completed result
- PAR_o  out  1  XOR-reduce of RES_o
- CHG_o  out  1  high if last result differed from the one before; valid from second scan
- IDX_o  out  clog2(NUM_REGS)  current register index

Behaviour:
- Reset (ARST_i high, async): state IDLE, BUSY_o=0, DONE_o=0, RES_o=0, PAR_o=0, CHG_o=0, IDX_o=0, accumulator=0, result-valid flag=0.
- FSM states: IDLE, SCAN, FIN. Transitions are taken only on cycles with CK_EE_i=1; with CK_EE_i=0 every register holds, and DONE_o is forced 0.
- IDLE:
  - START_i=1 -> latch MODE_i into mode_q.
  - Accumulator <= CRC_INIT if mode_q=CRC, else 0.
  - IDX <= 0, -> SCAN.
- SCAN, each enabled cycle:
  - acc <= f(acc, reg[IDX]).
  - SUM: acc + zero-extended reg, mod 2^ACC_W.
  - XOR: acc ^ zero-extended reg.
  - CRC: REG_W serial CRC steps, MSB of reg first, combinational unroll in one cycle.
  - IDX increments; at IDX=NUM_REGS-1 -> FIN, and IDX wraps to 0.
- FIN, one enabled cycle:
  - RES_o <= acc; DONE_o=1 registered, visible the following cycle.
  - CHG_o <= valid & (acc != RES_o); valid <= 1.
  - If CONT_i=1: re-initialise acc, re-latch MODE_i, -> SCAN. Otherwise -> IDLE.
- BUSY_o=1 in SCAN and FIN.
- Latency: START accepted at cycle t -> DONE_o high at t+NUM_REGS+2 (all enables high).
- DATss_i is sampled live per index, not snapshotted; a change mid-scan affects only registers not yet visited.
- START_i while busy is ignored. MODE_i changes mid-scan are ignored until the next latch.
- CONT_i deasserted mid-scan: the current scan completes, then the FSM returns to IDLE.
- Reset mid-scan: immediate return to reset values; no DONE pulse.

Decomposition:
- Shared package: mode encodings (MODE_SUM=0, MODE_XOR=1, MODE_CRC=2), FSM state encodings, and a clog2 function.
- One natural sub-module, reg_scan_crc_step: combinational, parameters ACC_W/REG_W/CRC_POLY; (crc_in, data) -> crc_out.

Test Plan:
- NUM_REGS=4, REG_W=8, ACC_W=8; regs {01,02,03,04}, MODE=0, START pulse -> DONE one cycle, RES_o=0x0A, PAR_o=0, CHG_o=0, latency 6 cycles.
- Same regs, MODE=1 -> RES_o=0x04. Then regs {FF,FF,FF,FF}, MODE=0 -> RES_o=0xFC (wrap), CHG_o=1.
- Regs {01,00,00,00}, MODE=2, POLY 0x07, INIT 0 -> RES_o=0x16. Single-register check on {01} with NUM_REGS=1 variant excluded; step module unit test: crc(0x00,0x01)=0x07.
- CONT_i=1 with static regs -> DONE every 5 cycles, CHG_o=0 after the first. Flip reg2 once -> CHG_o=1 for exactly one result.
- CK_EE_i toggling 1/0 during a scan -> identical RES_o, DONE at twice the latency. START_i held during SCAN -> no restart.
- ARST_i asserted at IDX=2 -> all outputs reset immediately, no DONE. After release with START -> a fresh full scan yields the correct result.
